alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//   Issue/retire stage wrapped around the combinational alu (a, b, op -> result, cero).
//   Buffers incoming {a, b, op} requests in a DEPTH-entry FIFO and drives the head entry onto the ALU.
//   Registers the ALU result and zero flag into an output holding register with a valid/ready handshake.
//   Sits between instruction decode (upstream) and writeback (downstream).
// PARAMETERS
//   WIDTH  32  operand/result width; matches alu a, b, result
//   DEPTH  4   FIFO entries; power of 2, >= 2
// PORTS
//   clk         in   1      rising-edge clock; single clock domain
//   reset       in   1      synchronous, active-high reset
//   in_valid    in   1      upstream request valid
//   in_ready    out  1      stage can accept a request this cycle
//   in_a        in   WIDTH  operand A
//   in_b        in   WIDTH  operand B
//   in_op       in   4      ALU opcode, passed through unmodified
//   alu_a       out  WIDTH  to alu.a
//   alu_b       out  WIDTH  to alu.b
//   alu_op      out  4      to alu.op
//   alu_result  in   WIDTH  from alu.result
//   alu_cero    in   1      from alu.cero
//   out_valid   out  1      out_result/out_zero hold a valid result
//   out_ready   in   1      downstream accepts result
//   out_result  out  WIDTH  registered ALU result
//   out_zero    out  1      registered ALU zero flag
//   count       out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
// BEHAVIOUR
// - Reset: count=0, read/write pointers=0, out_valid=0, out_result=0, out_zero=0.
//   Reset mid-operation discards all queued requests and any held result.
// - Push: in_valid && in_ready at the clock edge writes {in_a, in_b, in_op} at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
// - in_ready = (count < DEPTH). It is registered-state only, with no combinational path from out_ready.
//   When the FIFO is full, a same-cycle pop does not open a push slot.
// - ALU drive: alu_a/alu_b/alu_op = head entry when count>0; otherwise all zero.
// - Advance condition adv = (count>0) && (!out_valid || out_ready).
//   On adv: out_result<=alu_result, out_zero<=alu_cero, out_valid<=1, pop head, rd_ptr wraps.
// - When out_valid && out_ready && count==0: out_valid<=0. out_result/out_zero hold their last value.
// - When out_valid && !out_ready: out_* are held stable, no pop, and the FIFO keeps filling until full.
// - Simultaneous push and pop: count is unchanged, and both pointers advance.
// - Latency: request accepted at edge N appears on out_* after edge N+1 (empty queue, no stall).
//   Throughput is 1 result/cycle.
// - Ordering: results retire strictly in acceptance order. There are no drops and no duplicates.
// - Opcodes are not checked here; undefined opcodes yield whatever alu produces.
// CONFIGURATION
//   ALU_BYPASS_EN
//   - Defined: when count==0 and in_valid and adv-eligible (!out_valid || out_ready), in_* drive alu_* directly.
//     The result is captured at that same edge without writing the FIFO; latency is 1 edge.
//     in_ready is unchanged.
//   - Undefined: every request passes through the FIFO (latency 2 edges), and alu_* never depend on in_*.
// TESTING
// 1. Reset held 2 cycles with in_valid=1 -> count=0, out_valid=0, out_result=0, in_ready=1 after release.
// 2. a=4, b=5, op=4'b0010 (add) pushed once -> out_result=9, out_zero=0.
//    out_valid rises after the 2nd edge (1st edge with ALU_BYPASS_EN).
// 3. a=5, b=5, op=4'b0110 (sub) -> out_result=0, out_zero=1.
// 4. out_ready=0; push 5 requests back-to-back with DEPTH=4.
//    -> one result held in the output register, count=4, in_ready=0, 6th request stalls.
//    Release out_ready -> all 5 retire in order.
// 5. Streaming 8 requests with out_ready=1 and in_valid=1 continuously.
//    -> one result/cycle, in order, pointers wrap twice, count stays <=1.
// 6. Assert reset with count=3 and out_valid=1 -> next cycle count=0, out_valid=0.
//    Queued requests never appear.

Source files
------------

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage
// Description : Issue/retire stage around a combinational ALU. Requests
//               {a, b, op} are queued in a DEPTH-entry FIFO. The head entry
//               drives the ALU. The ALU result and zero flag are captured into
//               an output holding register with a valid/ready handshake.
// Optional    : `define ALU_BYPASS_EN lets a request that arrives at an empty
//               queue drive the ALU directly. Its result is captured at the
//               same edge, without a FIFO write.
// Ports       : clk, reset (sync, active-high)
//               in_valid/in_ready/in_a/in_b/in_op     : upstream request
//               alu_a/alu_b/alu_op -> ALU, alu_result/alu_cero <- ALU
//               out_valid/out_ready/out_result/out_zero : downstream result
//               count : FIFO occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [3:0]               in_op,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [3:0]               alu_op,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_cero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_zero,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] a_mem  [DEPTH];
  logic [WIDTH-1:0] b_mem  [DEPTH];
  logic [3:0]       op_mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic not_empty;
  logic adv_ok;
  logic pop;
  logic push;
  logic bypass;
  logic capture;

  assign not_empty = (count != '0);
  // Full is judged on registered occupancy only, so a same-cycle pop never
  // opens a slot and there is no path from out_ready to in_ready.
  assign in_ready  = (count < DEPTH_C);
  // The output register can take a new value if it is empty or being drained.
  assign adv_ok    = !out_valid || out_ready;
  assign pop       = not_empty && adv_ok;

`ifdef ALU_BYPASS_EN
  assign bypass = !not_empty && in_valid && adv_ok;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed request is consumed straight into the output register and
  // never occupies a FIFO slot.
  assign push    = in_valid && in_ready && !bypass;
  assign capture = pop || bypass;

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (not_empty) begin
      alu_a  = a_mem[rd_ptr];
      alu_b  = b_mem[rd_ptr];
      alu_op = op_mem[rd_ptr];
    end
`ifdef ALU_BYPASS_EN
    else if (bypass) begin
      alu_a  = in_a;
      alu_b  = in_b;
      alu_op = in_op;
    end
`endif
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr]  <= in_a;
      b_mem[wr_ptr]  <= in_b;
      op_mem[wr_ptr] <= in_op;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
    end else if (capture) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      out_zero   <= alu_cero;
    end else if (out_valid && out_ready) begin
      // Drained with nothing behind it; the data stays as last retired.
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_stage
// Description : Randomized self-checking bench for alu_issue_stage. A small
//               ALU stand-in closes the alu_* loop. A queue-based reference
//               model predicts the visible state every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
`ifdef ALU_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_cero;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic [2:0]       count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cero(alu_cero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .count(count)
  );

  function automatic logic [WIDTH-1:0] alu_f(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [3:0] op);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return ~(a | b);
    endcase
  endfunction

  // ALU stand-in driven by the DUT.
  assign alu_result = alu_f(alu_a, alu_b, alu_op);
  assign alu_cero   = (alu_result == '0);

  // Reference model: pending requests plus the output register contents.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
  } req_t;
  req_t             mq[$];
  logic             m_ov;
  logic [WIDTH-1:0] m_res;
  logic             m_zero;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_ov   = 1'b0;
    m_res  = '0;
    m_zero = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_a      = 32'hdead_beef;
    in_b      = 32'h1234_5678;
    in_op     = OP_ADD;
    out_ready = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  // One clock cycle: apply inputs, compare against the model, advance both.
  task automatic step(input logic v, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic [3:0] op,
                      input logic ordy);
    logic adv_ok, byp, accept;
    req_t hd, r;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    out_ready = ordy;
    #1;
    check("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
    check("count", 64'(count), 64'(mq.size()));
    check("out_valid", 64'(out_valid), 64'(m_ov));
    check("out_result", 64'(out_result), 64'(m_res));
    check("out_zero", 64'(out_zero), 64'(m_zero));

    adv_ok = !m_ov || ordy;
    byp    = BYP && (mq.size() == 0) && v && adv_ok;
    accept = v && (mq.size() < DEPTH);
    r      = '{a: a, b: b, op: op};

    if (mq.size() > 0) begin
      hd = mq[0];
      check("alu_a", 64'(alu_a), 64'(hd.a));
      check("alu_b", 64'(alu_b), 64'(hd.b));
      check("alu_op", 64'(alu_op), 64'(hd.op));
    end else if (byp) begin
      check("alu_byp", {alu_a, alu_b}, {a, b});
    end else begin
      check("alu_idle", {alu_a, alu_b}, 64'(0));
      check("alu_op_idle", 64'(alu_op), 64'(0));
    end

    if (mq.size() > 0 && adv_ok) begin
      hd     = mq.pop_front();
      m_res  = alu_f(hd.a, hd.b, hd.op);
      m_zero = (m_res == '0);
      m_ov   = 1'b1;
    end else if (byp) begin
      m_res  = alu_f(a, b, op);
      m_zero = (m_res == '0);
      m_ov   = 1'b1;
    end else if (m_ov && ordy) begin
      m_ov = 1'b0;
    end
    if (accept && !byp) mq.push_back(r);

    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic [3:0]       rop;

    // Reset held two cycles with in_valid asserted.
    do_reset(2);
    check("rst_count", 64'(count), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_result", 64'(out_result), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // Single add: latency is one or two edges depending on bypass.
    step(1'b1, 32'd4, 32'd5, OP_ADD, 1'b1);
    check("lat_first_edge", 64'(out_valid), 64'(BYP));
    step(1'b0, 32'd0, 32'd0, OP_AND, 1'b1);
    check("add_result", 64'(out_result), 64'(9));
    check("add_zero", 64'(out_zero), 64'(0));
    repeat (2) step(1'b0, 32'd0, 32'd0, OP_AND, 1'b1);

    // Sub of equal operands sets the zero flag.
    step(1'b1, 32'd5, 32'd5, OP_SUB, 1'b1);
    step(1'b0, 32'd0, 32'd0, OP_AND, 1'b1);
    check("sub_result", 64'(out_result), 64'(0));
    check("sub_zero", 64'(out_zero), 64'(1));
    repeat (2) step(1'b0, 32'd0, 32'd0, OP_AND, 1'b1);

    // Stalled output: five pushes fill output reg + FIFO, sixth stalls.
    for (int i = 0; i < 6; i++)
      step(1'b1, 32'(100 + i), 32'(i), OP_ADD, 1'b0);
    check("stall_count", 64'(count), 64'(DEPTH));
    check("stall_in_ready", 64'(in_ready), 64'(0));
    check("stall_out_valid", 64'(out_valid), 64'(1));
    for (int i = 0; i < 8; i++)
      step(1'b0, 32'd0, 32'd0, OP_AND, 1'b1);
    check("drain_count", 64'(count), 64'(0));

    // Streaming: one result per cycle, occupancy never exceeds one.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'(7 * i), 32'(3), OP_SUB, 1'b1);
      check("stream_count_le1", 64'(count <= 1), 64'(1));
    end
    repeat (3) step(1'b0, 32'd0, 32'd0, OP_AND, 1'b1);

    // Reset with three queued entries and a held result.
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'(40 + i), 32'(2), OP_OR, 1'b0);
    check("pre_rst_count", 64'(count), 64'(3));
    check("pre_rst_out_valid", 64'(out_valid), 64'(1));
    do_reset(1);
    check("mid_rst_count", 64'(count), 64'(0));
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    repeat (5) step(1'b0, 32'd0, 32'd0, OP_AND, 1'b1);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      rop = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) rop = OP_SUB;
      step(1'($urandom_range(0, 99) < 65), ra, rb, rop,
           1'($urandom_range(0, 99) < 60));
    end
    for (int i = 0; i < 10; i++)
      step(1'b0, 32'd0, 32'd0, OP_AND, 1'b1);
    check("final_count", 64'(count), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
